rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one synchronous single-port ROM read port (1-cycle registered read latency) among NUM_REQ requesters.
- Each requester has a valid/ready address channel and a valid/ready data channel.
- Round-robin arbitration; one read outstanding at a time.
- Sits between client blocks (table lookups, sequencers) and the ROM instance.

Parameters:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 8, ROM address width.
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester address valid.
- req_ready_o  out  NUM_REQ  per-requester address ready.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rsp_valid_o  out  NUM_REQ  per-requester data valid; at most one bit set.
- rsp_ready_i  in  NUM_REQ  per-requester data ready.
- rsp_data_o  out  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid_o.
- rom_addr_o  out  ADDR_WIDTH  registered address to ROM.
- rom_data_i  in  DATA_WIDTH  ROM registered output.

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE.
  - rsp_valid_o=0, rsp_data_o=0, rom_addr_o=0.
  - grant_q=0, last_q=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides any in-flight transaction; the pending response is discarded and no rsp_valid_o follows.
- FSM states: IDLE, ROM_RD, CAPT, RESP.
- IDLE:
  - Arbiter scans from (last_q+1) mod NUM_REQ upward with wrap and selects the first k with req_valid_i[k]=1.
  - req_ready_o[k]=1 combinationally for the selected k only; all other ready bits are 0.
  - req_ready_o is 0 in every state other than IDLE.
  - On handshake at posedge: rom_addr_o<=addr of k, grant_q<=k, state->ROM_RD.
  - No request valid: stay in IDLE; rom_addr_o holds its value.
- ROM_RD: ROM samples rom_addr_o at this edge; state->CAPT.
- CAPT:
  - rom_data_i is valid in this cycle.
  - At posedge: rsp_data_o<=rom_data_i, rsp_valid_o[grant_q]<=1, state->RESP.
- RESP:
  - rsp_valid_o[grant_q] and rsp_data_o are held stable until rsp_ready_i[grant_q]=1.
  - rsp_ready_i of non-granted requesters is ignored.
  - On handshake at posedge: rsp_valid_o<=0, last_q<=grant_q, state->IDLE.
- Timing:
  - Latency: request handshake in cycle N -> rsp_valid_o high in cycle N+3.
  - Maximum throughput: 1 read per 4 cycles, with rsp_ready_i tied high and back-to-back valid requests.
- Request-side rules:
  - Requesters must hold req_valid_i and addr stable until ready.
  - req_valid_i may drop before a grant; no transaction then occurs.
  - req_ready_o depends combinationally on req_valid_i; requesters must not make req_valid_i depend on req_ready_o.
- Simultaneous events:
  - All requesters valid in IDLE: service order is strictly rotating (0,1,...,NUM_REQ-1,0,...).
  - A single requester repeating: it is granted every time; no idle gap beyond the 4-cycle cadence.
- rom_addr_o is registered, so there is no combinational path from req_addr_i to the ROM.

Test Plan:
- Reset values: hold rst_i 2 cycles -> rsp_valid_o=0, rsp_data_o=0, rom_addr_o=0, req_ready_o=0 while no valid. Bench ROM model returns addr^8'hA5 one cycle after address.
- Single read: req0 addr 8'h10 valid at cycle 5 -> req_ready_o=2'b01 in cycle 5; rom_addr_o=8'h10 in cycle 6; rsp_valid_o=2'b01 with rsp_data_o=8'hB5 in cycle 8; rsp_ready_i=1 -> valid clears in cycle 9.
- Contention: req0 (8'h01) and req1 (8'h02) both held valid from reset; rsp_ready_i=2'b11 -> grants in order 0,1,0,1; data 8'hA4, 8'hA7, ...; grants 4 cycles apart.
- Backpressure: rsp_ready_i[0]=0 for 5 cycles after rsp_valid_o[0] rises -> rsp_data_o stable; req_ready_o=0 throughout; req1 is granted only in the cycle after the rsp handshake.
- Wrong-ready ignored: rsp_valid_o[1]=1, rsp_ready_i=2'b01 -> no handshake; rsp_valid_o stays 2'b10.
- Reset mid-flight: assert rst_i in CAPT -> next cycle state IDLE, rsp_valid_o=0; no stale response ever appears; the next request is serviced normally with requester 0 priority.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares the read port of one synchronous single-port ROM (one-cycle
// registered read latency) among NUM_REQ clients. Each client has a
// valid/ready address channel and a valid/ready data channel. Arbitration is
// round-robin and only one read is in flight at a time, which gives a fixed
// four-cycle cadence per read: IDLE (grant) -> ROM_RD -> CAPT -> RESP.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-client address valid
//   req_ready_o  per-client address ready (one-hot, only ever set in IDLE)
//   req_addr_i   packed addresses, client k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rsp_valid_o  per-client data valid (at most one bit set)
//   rsp_ready_i  per-client data ready (only the granted client's bit is used)
//   rsp_data_o   read data shared by all clients, qualified by rsp_valid_o
//   rom_addr_o   registered ROM address
//   rom_data_i   registered ROM read data
// -----------------------------------------------------------------------------
module rom_read_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REQ    = 2   // legal range 2..8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   input  logic [NUM_REQ-1:0]            rsp_ready_i,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic [ADDR_WIDTH-1:0]         rom_addr_o,
   input  logic [DATA_WIDTH-1:0]         rom_data_i
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE,    // arbitrate and accept one address
      ROM_RD,  // ROM samples rom_addr_o at the end of this cycle
      CAPT,    // rom_data_i is valid, capture it
      RESP     // hold the response until the granted client takes it
   } state_e;

   state_e                  state_q,     state_d;
   idx_t                    grant_q,     grant_d;
   idx_t                    last_q,      last_d;
   logic [ADDR_WIDTH-1:0]   rom_addr_q,  rom_addr_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;

   logic                    sel_found;
   idx_t                    sel_idx;

   // Round-robin pick: scan from the client after the last one served,
   // wrapping at NUM_REQ, and take the first one with a valid request.
   // NUM_REQ need not be a power of two, so the wrap is explicit.
   always_comb begin
      int unsigned cand;
      // NOTE: every variable written here gets a default before any branch,
      // so no path leaves it unassigned and no latch is inferred.
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!sel_found && req_valid_i[idx_t'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = idx_t'(cand);
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      rom_addr_d  = rom_addr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      req_ready_o = '0;

      unique case (state_q)
         IDLE: begin
            // Ready is only raised towards a client that is already valid,
            // so raising it means the handshake happens at this edge.
            if (sel_found) begin
               req_ready_o[sel_idx] = 1'b1;
               rom_addr_d           = req_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
               grant_d              = sel_idx;
               state_d              = ROM_RD;
            end
         end

         ROM_RD: begin
            state_d = CAPT;
         end

         CAPT: begin
            rsp_data_d           = rom_data_i;
            rsp_valid_d          = '0;
            rsp_valid_d[grant_q] = 1'b1;
            state_d              = RESP;
         end

         RESP: begin
            // Only the granted client's ready can complete the response.
            if (rsp_ready_i[grant_q]) begin
               rsp_valid_d = '0;
               last_d      = grant_q;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset also drops any read in flight, so a pending
   // response is discarded rather than delivered late.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop updates from the values
      // present before the edge, independent of statement order.
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= idx_t'(NUM_REQ - 1);  // client 0 gets first priority
         rom_addr_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         rom_addr_q  <= rom_addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Self-checking bench for rom_read_arbiter with NUM_REQ=2, 8-bit data and
// address. A ROM model returns addr ^ 8'hA5 one cycle after the address.
// Expected grants come from a rotating-priority rule kept as a single
// "last served" integer; expected data and timing come from the ROM rule and
// the fixed grant/read/capture/respond cadence. Directed steps cover reset,
// a single read, contention, backpressure, ignored wrong-client ready and
// reset during a read; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rom_read_arbiter;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NR = 2;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [NR-1:0]    req_valid_i;
   logic [NR-1:0]    req_ready_o;
   logic [NR*AW-1:0] req_addr_i;
   logic [NR-1:0]    rsp_valid_o;
   logic [NR-1:0]    rsp_ready_i;
   logic [DW-1:0]    rsp_data_o;
   logic [AW-1:0]    rom_addr_o;
   logic [DW-1:0]    rom_data_i;

   int               pass_cnt  = 0;
   int               check_cnt = 0;
   int               last      = NR - 1;  // reference: last client served
   logic [AW-1:0]    exp_rom_addr = '0;   // reference: last address issued

   rom_read_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rom_addr_o  (rom_addr_o),
      .rom_data_i  (rom_data_i)
   );

   always #5 clk_i = ~clk_i;

   // ROM model: registered read, data = addr ^ 8'hA5.
   always @(posedge clk_i) rom_data_i <= rom_addr_o ^ 8'hA5;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the negedge.
   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Rotating priority: first valid client after the last one served.
   function automatic int next_grant(input logic [NR-1:0] mask);
      for (int i = 1; i <= NR; i++) begin
         if (mask[(last + i) % NR]) return (last + i) % NR;
      end
      return -1;
   endfunction

   // One full read, entered at the negedge of an idle cycle with at least one
   // request valid. stall = cycles the granted client withholds rsp_ready.
   task automatic txn(input string tag, input int stall, input bit rand_others, output int k);
      logic [AW-1:0] a;
      logic [NR-1:0] onehot;
      k      = next_grant(req_valid_i);
      a      = req_addr_i[k*AW +: AW];
      onehot = NR'(1) << k;
      #1;
      check({tag, " grant"}, 32'(req_ready_o), 32'(onehot));
      cyc();  // address registered towards the ROM
      check({tag, " rom_addr"}, 32'(rom_addr_o), 32'(a));
      check({tag, " ready low rd"}, 32'(req_ready_o), 32'(0));
      check({tag, " no early rsp"}, 32'(rsp_valid_o), 32'(0));
      cyc();  // ROM data arriving
      check({tag, " no rsp capt"}, 32'(rsp_valid_o), 32'(0));
      check({tag, " ready low capt"}, 32'(req_ready_o), 32'(0));
      cyc();  // response visible three cycles after the grant
      check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(onehot));
      check({tag, " rsp_data"}, 32'(rsp_data_o), 32'(a ^ 8'hA5));
      for (int s = 0; s < stall; s++) begin
         rsp_ready_i    = rand_others ? NR'($urandom) : '1;
         rsp_ready_i[k] = 1'b0;
         cyc();
         check({tag, " hold valid"}, 32'(rsp_valid_o), 32'(onehot));
         check({tag, " hold data"}, 32'(rsp_data_o), 32'(a ^ 8'hA5));
         check({tag, " ready low resp"}, 32'(req_ready_o), 32'(0));
         check({tag, " hold rom_addr"}, 32'(rom_addr_o), 32'(a));
      end
      rsp_ready_i    = rand_others ? NR'($urandom) : '1;
      rsp_ready_i[k] = 1'b1;
      cyc();
      check({tag, " rsp cleared"}, 32'(rsp_valid_o), 32'(0));
      last         = k;
      exp_rom_addr = a;
   endtask

   initial begin
      int k_srv;

      // Reset held for two cycles with no requests.
      rst_i       = 1'b1;
      req_valid_i = '0;
      req_addr_i  = '0;
      rsp_ready_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("reset rsp_valid", 32'(rsp_valid_o), 32'(0));
      check("reset rsp_data", 32'(rsp_data_o), 32'(0));
      check("reset rom_addr", 32'(rom_addr_o), 32'(0));
      check("reset req_ready", 32'(req_ready_o), 32'(0));

      // Contention: both clients always valid, order 0,1,0,1.
      req_addr_i[0*AW +: AW] = 8'h01;
      req_addr_i[1*AW +: AW] = 8'h02;
      req_valid_i = 2'b11;
      rsp_ready_i = 2'b11;
      for (int t = 0; t < 4; t++) txn("contend", 0, 1'b0, k_srv);
      req_valid_i = '0;

      // Single read from client 0.
      req_addr_i[0*AW +: AW] = 8'h10;
      req_valid_i = 2'b01;
      txn("single", 0, 1'b0, k_srv);
      req_valid_i[k_srv] = 1'b0;

      // Client 1 response with only client 0's ready raised: ignored.
      req_addr_i[1*AW +: AW] = 8'h3C;
      req_valid_i = 2'b10;
      txn("wrong_ready", 3, 1'b0, k_srv);
      req_valid_i[k_srv] = 1'b0;

      // Backpressure on client 0 while client 1 waits.
      req_addr_i[0*AW +: AW] = 8'h55;
      req_addr_i[1*AW +: AW] = 8'hC3;
      req_valid_i = 2'b11;
      txn("bp first", 5, 1'b0, k_srv);
      req_valid_i[k_srv] = 1'b0;
      txn("bp second", 0, 1'b0, k_srv);
      req_valid_i[k_srv] = 1'b0;

      // Client 0 served last, so a plain restart would favour client 1.
      req_addr_i[0*AW +: AW] = 8'h77;
      req_valid_i = 2'b01;
      txn("pre_abort", 0, 1'b0, k_srv);
      req_valid_i[k_srv] = 1'b0;

      // Reset while client 1's read is in the capture cycle.
      req_addr_i[1*AW +: AW] = 8'h9E;
      req_valid_i = 2'b10;
      #1;
      check("abort grant", 32'(req_ready_o), 32'(2'b10));
      cyc();
      req_valid_i = '0;
      cyc();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      last         = NR - 1;
      exp_rom_addr = '0;
      check("abort rsp_valid", 32'(rsp_valid_o), 32'(0));
      check("abort rom_addr", 32'(rom_addr_o), 32'(0));
      for (int c = 0; c < 4; c++) begin
         cyc();
         check("abort no stale rsp", 32'(rsp_valid_o), 32'(0));
      end
      req_addr_i[0*AW +: AW] = 8'h21;
      req_addr_i[1*AW +: AW] = 8'h42;
      req_valid_i = 2'b11;
      txn("after_abort", 0, 1'b0, k_srv);
      req_valid_i = '0;

      // Randomized phase: clients raise, hold or withdraw requests at random.
      for (int t = 0; t < 40; t++) begin
         for (int r = 0; r < NR; r++) begin
            if (!req_valid_i[r]) begin
               if ($urandom_range(1, 0) == 1) begin
                  req_valid_i[r]        = 1'b1;
                  req_addr_i[r*AW +: AW] = AW'($urandom);
               end
            end else if ($urandom_range(7, 0) == 0) begin
               req_valid_i[r] = 1'b0;
            end
         end
         if (req_valid_i == '0) begin
            #1;
            check("idle req_ready", 32'(req_ready_o), 32'(0));
            check("idle rom_addr", 32'(rom_addr_o), 32'(exp_rom_addr));
            check("idle rsp_valid", 32'(rsp_valid_o), 32'(0));
            cyc();
         end else begin
            txn("rand", int'($urandom_range(3, 0)), 1'b1, k_srv);
            req_valid_i[k_srv] = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
